// File: rtl/ram_loader.sv
// Programming-mode loader for the SAP-1 memory path: takes host words over valid/ready
// and writes them into RAM from address 0 upward while holding the CPU in clear.
module ram_loader #(
   parameter int AW        = 4,
   parameter int DW        = 8,
   parameter int WE_CYCLES = 2
) (
   input  logic          CLK,
   input  logic          CLR_n,
   input  logic          START,
   input  logic [DW-1:0] IN_DATA,
   input  logic          IN_VALID,
   input  logic          IN_LAST,
   output logic          IN_READY,
   output logic          SELECT,
   output logic [AW-1:0] ADDR,
   output logic [DW-1:0] RAM_DIN,
   output logic          RAM_WE,
   output logic          CPU_HOLD,
   output logic          BUSY,
   output logic          DONE,
   output logic [AW:0]   WORDS,
   output logic          ERR
);

   localparam int            CW       = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
   localparam logic [CW-1:0] WE_LAST  = CW'(WE_CYCLES - 1);
   localparam logic [AW-1:0] ADDR_MAX = '1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_WRITE,
      ST_HOLD,
      ST_FINISH
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] din_q, din_d;
   logic [AW:0]   words_q, words_d;
   logic          err_q, err_d;
   logic          last_q, last_d;
   logic [CW-1:0] we_cnt_q, we_cnt_d;

   logic          in_ready_q, in_ready_d;
   logic          select_q, select_d;
   logic          ram_we_q, ram_we_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   always_ff @(posedge CLK or negedge CLR_n) begin
      if (!CLR_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         din_q      <= '0;
         words_q    <= '0;
         err_q      <= 1'b0;
         last_q     <= 1'b0;
         we_cnt_q   <= '0;
         in_ready_q <= 1'b0;
         select_q   <= 1'b1;
         ram_we_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         words_q    <= words_d;
         err_q      <= err_d;
         last_q     <= last_d;
         we_cnt_q   <= we_cnt_d;
         in_ready_q <= in_ready_d;
         select_q   <= select_d;
         ram_we_q   <= ram_we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Next-state and datapath updates; in_ready_q mirrors "state is SETUP".
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      din_d    = din_q;
      words_d  = words_q;
      err_d    = err_q;
      last_d   = last_q;
      we_cnt_d = we_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d = ST_SETUP;
               addr_d  = '0;
               words_d = '0;
               err_d   = 1'b0;
               last_d  = 1'b0;
            end
         end
         ST_SETUP: begin
            if (IN_VALID && in_ready_q) begin
               din_d    = IN_DATA;
               last_d   = IN_LAST;
               words_d  = words_q + 1'b1;
               we_cnt_d = '0;
               state_d  = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (we_cnt_q == WE_LAST) begin
               state_d = ST_HOLD;
            end else begin
               we_cnt_d = we_cnt_q + 1'b1;
            end
         end
         ST_HOLD: begin
            // Address advances only here, after the strobe has dropped.
            if (last_q) begin
               state_d = ST_FINISH;
            end else if (addr_q == ADDR_MAX) begin
               err_d   = 1'b1;
               state_d = ST_FINISH;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = ST_SETUP;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control outputs are decoded from the next state so they leave flops directly.
   always_comb begin
      in_ready_d = (state_d == ST_SETUP);
      select_d   = (state_d == ST_IDLE);
      ram_we_d   = (state_d == ST_WRITE);
      busy_d     = (state_d != ST_IDLE);
      done_d     = (state_d == ST_FINISH);
   end

   assign IN_READY = in_ready_q;
   assign SELECT   = select_q;
   assign CPU_HOLD = ~select_q;
   assign ADDR     = addr_q;
   assign RAM_DIN  = din_q;
   assign RAM_WE   = ram_we_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign WORDS    = words_q;
   assign ERR      = err_q;

endmodule

// File: doc/ram_loader.md
# ram_loader

Programming-mode front end for the SAP-1 memory path. It accepts a stream of 8-bit words from a host source (switch panel debouncer or UART receiver) over a valid/ready handshake. It drives the MAR's programming-address input and mode select, plus the RAM write data and write strobe, filling RAM from address 0 upward. While loading, it holds the CPU controller in clear and returns the MAR to execution mode when finished.

## Interface
- AW, 4, address width; RAM depth is 2**AW words
- DW, 8, data word width
- WE_CYCLES, 2, RAM_WE high time in clock cycles per word (>=1)

- CLK  input  1  system clock, rising-edge
- CLR_n  input  1  reset, asynchronous assert, active-low
- START  input  1  one-cycle request to begin a load; ignored unless IDLE
- IN_DATA  input  DW  word from host
- IN_VALID  input  1  IN_DATA valid
- IN_LAST  input  1  qualifies IN_DATA as final word of the program
- IN_READY  output  1  loader will accept a word this cycle
- SELECT  output  1  to MAR mode select: 0 = programming (ADDR drives RAM address), 1 = execution
- ADDR  output  AW  to MAR programming-address input
- RAM_DIN  output  DW  RAM write data
- RAM_WE  output  1  RAM write strobe, active-high
- CPU_HOLD  output  1  keeps controller/PC in clear while high
- BUSY  output  1  load in progress (any state but IDLE)
- DONE  output  1  one-cycle pulse at end of load
- WORDS  output  AW+1  count of words written in current/last load
- ERR  output  1  sticky overflow: RAM filled without IN_LAST seen

## Operation
- States: IDLE, SETUP, WRITE, HOLD, FINISH.
- IDLE: SELECT=1, CPU_HOLD=0, IN_READY=0. START → SETUP; same edge clears ADDR, WORDS, ERR.
- SETUP: SELECT=0, CPU_HOLD=1, IN_READY=1. On IN_VALID&IN_READY: capture IN_DATA into RAM_DIN and IN_LAST into an internal flag, WORDS+1, → WRITE. Otherwise stay.
- WRITE: RAM_WE=1 for exactly WE_CYCLES cycles (internal counter), IN_READY=0, ADDR and RAM_DIN stable → HOLD.
- HOLD: one cycle, RAM_WE=0, ADDR/RAM_DIN still stable (hold time). Then:
  - last flag set → FINISH;
  - else ADDR == 2**AW-1 → set ERR, → FINISH;
  - else ADDR+1, → SETUP.
- FINISH: one cycle, DONE=1, SELECT=0, CPU_HOLD=1 → IDLE.
- ADDR never wraps; it stays at the last written address after a load. WORDS saturates naturally at 2**AW (width AW+1).
- START outside IDLE is ignored. IN_VALID outside SETUP is ignored; the host must hold the word until accepted.
- RAM_DIN retains the last written word in IDLE; WORDS and ERR persist until the next START.

## Timing
- Reset values (async, CLR_n low): state IDLE, SELECT=1, ADDR=0, RAM_DIN=0, RAM_WE=0, IN_READY=0, CPU_HOLD=0, BUSY=0, DONE=0, WORDS=0, ERR=0.
- Reset mid-load aborts immediately. RAM_WE drops asynchronously, and RAM contents already written are left as they are.
- START sampled at edge t → SETUP from t+1, IN_READY high at t+1.
- Word accepted at edge t → RAM_WE high during cycles t+1..t+WE_CYCLES, HOLD at t+WE_CYCLES+1, next SETUP at t+WE_CYCLES+2. Default throughput is one word per 4 cycles.
- Final word accepted at edge t → DONE high in cycle t+WE_CYCLES+2. SELECT=1 and CPU_HOLD=0 from t+WE_CYCLES+3.
- All outputs are registered. No combinational path exists from IN_VALID to IN_READY.
- ADDR changes only on the HOLD→SETUP edge, never while RAM_WE=1.

## Test plan
- Reset with CLR_n low mid-cycle: all outputs are at the reset values listed above, asynchronously, before the next CLK edge.
- START, then 3 words 0x1E, 0x2F, 0xE0 (the last with IN_LAST): RAM writes at addresses 0, 1, 2. Each RAM_WE pulse lasts 2 cycles. After the load, WORDS=3, ERR=0, one DONE pulse, ADDR=2, then SELECT returns to 1.
- 16 words, none with IN_LAST: all 16 written, ERR=1, WORDS=16, DONE pulses. A 17th IN_VALID is never accepted (IN_READY stays 0).
- IN_VALID toggling with gaps, and START pulsed during WRITE: the loader stalls in SETUP, the START is ignored, and no duplicate or skipped address occurs.
- CLR_n asserted during WRITE of the word at address 5: RAM_WE drops at once. The next START restarts at ADDR=0 with WORDS=0 and ERR=0.
- WE_CYCLES=1 variant: accepts one word every 3 cycles, and ADDR is never seen to change while RAM_WE=1.
